// File: rtl/reorder25_sched.sv
// Round-robin frame scheduler feeding the 25-point reorder buffer: one N-sample frame per grant, drain, then a single GAP cycle.
// Optional DRAIN watchdog (err_timeout / rb_rst ports) is enabled by defining REORDER_SCHED_TIMEOUT_EN.
module reorder25_sched #(
    parameter int WIDTH = 18,
    parameter int N     = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic                    req1,
    input  logic signed [WIDTH-1:0] s0_re,
    input  logic signed [WIDTH-1:0] s0_im,
    input  logic signed [WIDTH-1:0] s1_re,
    input  logic signed [WIDTH-1:0] s1_im,
    input  logic                    s0_valid,
    input  logic                    s1_valid,
    output logic                    s0_ready,
    output logic                    s1_ready,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic signed [WIDTH-1:0] rb_di_re,
    output logic signed [WIDTH-1:0] rb_di_im,
    output logic                    rb_di_en,
    input  logic                    rb_do_en,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    frame_src,
    output logic                    err_underrun
`ifdef REORDER_SCHED_TIMEOUT_EN
    ,
    output logic                    err_timeout,
    output logic                    rb_rst
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_GAP} state_t;

    state_t         state_reg, state_next;
    logic           gnt0_reg, gnt0_next;
    logic           gnt1_reg, gnt1_next;
    logic           sel_reg, sel_next;
    logic           last_reg, last_next;
    logic [CW-1:0]  load_cnt_reg, load_cnt_next;
    logic [CW-1:0]  drain_cnt_reg, drain_cnt_next;
    logic           done_reg, done_next;
    logic           frame_done_reg, frame_done_next;
    logic           frame_src_reg, frame_src_next;
    logic           underrun_reg, underrun_next;
    logic           di_en_reg, di_en_next;
    logic           busy_reg, busy_next;
    logic           cur_valid;

`ifdef REORDER_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(2 * N + 1);
    logic [WW-1:0]  wd_cnt_reg, wd_cnt_next;
    logic           timeout_reg, timeout_next;
`endif

    assign cur_valid = sel_reg ? s1_valid : s0_valid;

    always_comb begin
        state_next      = state_reg;
        gnt0_next       = gnt0_reg;
        gnt1_next       = gnt1_reg;
        sel_next        = sel_reg;
        last_next       = last_reg;
        load_cnt_next   = load_cnt_reg;
        drain_cnt_next  = drain_cnt_reg;
        done_next       = done_reg;
        frame_done_next = 1'b0;
        frame_src_next  = frame_src_reg;
        underrun_next   = 1'b0;
`ifdef REORDER_SCHED_TIMEOUT_EN
        wd_cnt_next     = wd_cnt_reg;
        timeout_next    = 1'b0;
`endif
        unique case (state_reg)
            S_IDLE: begin
                // On a tie, last_reg names the requester served most recently.
                if (req0 && (!req1 || last_reg)) begin
                    state_next    = S_LOAD;
                    sel_next      = 1'b0;
                    gnt0_next     = 1'b1;
                    load_cnt_next = '0;
                end else if (req1) begin
                    state_next    = S_LOAD;
                    sel_next      = 1'b1;
                    gnt1_next     = 1'b1;
                    load_cnt_next = '0;
                end
            end
            S_LOAD: begin
                underrun_next = !cur_valid;
                if (load_cnt_reg == CW'(N - 1)) begin
                    state_next     = S_DRAIN;
                    gnt0_next      = 1'b0;
                    gnt1_next      = 1'b0;
                    last_next      = sel_reg;
                    drain_cnt_next = '0;
                    done_next      = 1'b0;
`ifdef REORDER_SCHED_TIMEOUT_EN
                    wd_cnt_next    = '0;
`endif
                end else begin
                    load_cnt_next = load_cnt_reg + CW'(1);
                end
            end
            S_DRAIN: begin
                // done_reg holds DRAIN for the cycle frame_done (or err_timeout) is visible.
                if (done_reg) begin
                    state_next = S_GAP;
                end else begin
                    if (rb_do_en) begin
                        drain_cnt_next = drain_cnt_reg + CW'(1);
                        if (drain_cnt_reg == CW'(N - 1)) begin
                            frame_done_next = 1'b1;
                            frame_src_next  = sel_reg;
                            done_next       = 1'b1;
                        end
                    end
`ifdef REORDER_SCHED_TIMEOUT_EN
                    wd_cnt_next = wd_cnt_reg + WW'(1);
                    if (wd_cnt_reg == WW'(2 * N - 1) &&
                        !(rb_do_en && drain_cnt_reg == CW'(N - 1))) begin
                        timeout_next = 1'b1;
                        done_next    = 1'b1;
                    end
`endif
                end
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        di_en_next = (state_next == S_LOAD);
        busy_next  = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
            sel_reg        <= 1'b0;
            last_reg       <= 1'b1;
            load_cnt_reg   <= '0;
            drain_cnt_reg  <= '0;
            done_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_src_reg  <= 1'b0;
            underrun_reg   <= 1'b0;
            di_en_reg      <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef REORDER_SCHED_TIMEOUT_EN
            wd_cnt_reg     <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            gnt0_reg       <= gnt0_next;
            gnt1_reg       <= gnt1_next;
            sel_reg        <= sel_next;
            last_reg       <= last_next;
            load_cnt_reg   <= load_cnt_next;
            drain_cnt_reg  <= drain_cnt_next;
            done_reg       <= done_next;
            frame_done_reg <= frame_done_next;
            frame_src_reg  <= frame_src_next;
            underrun_reg   <= underrun_next;
            di_en_reg      <= di_en_next;
            busy_reg       <= busy_next;
`ifdef REORDER_SCHED_TIMEOUT_EN
            wd_cnt_reg     <= wd_cnt_next;
            timeout_reg    <= timeout_next;
`endif
        end
    end

    // Missing samples are zero-filled so the frame length never changes.
    always_comb begin
        rb_di_re = '0;
        rb_di_im = '0;
        if (di_en_reg && cur_valid) begin
            rb_di_re = sel_reg ? s1_re : s0_re;
            rb_di_im = sel_reg ? s1_im : s0_im;
        end
    end

    assign s0_ready     = gnt0_reg;
    assign s1_ready     = gnt1_reg;
    assign gnt0         = gnt0_reg;
    assign gnt1         = gnt1_reg;
    assign rb_di_en     = di_en_reg;
    assign busy         = busy_reg;
    assign frame_done   = frame_done_reg;
    assign frame_src    = frame_src_reg;
    assign err_underrun = underrun_reg;
`ifdef REORDER_SCHED_TIMEOUT_EN
    assign err_timeout  = timeout_reg;
    assign rb_rst       = timeout_reg;
`endif

endmodule

// File: tb/tb_reorder25_sched.sv
// Directed bench for reorder25_sched: single frame, underrun, reset mid-LOAD, tie arbitration and GAP spacing.
module tb_reorder25_sched;
    localparam int WIDTH = 18;
    localparam int N     = 25;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req0, req1;
    logic signed [WIDTH-1:0] s0_re, s0_im, s1_re, s1_im;
    logic                    s0_valid, s1_valid;
    logic                    s0_ready, s1_ready;
    logic                    gnt0, gnt1;
    logic signed [WIDTH-1:0] rb_di_re, rb_di_im;
    logic                    rb_di_en;
    logic                    rb_do_en;
    logic                    busy, frame_done, frame_src, err_underrun;
`ifdef REORDER_SCHED_TIMEOUT_EN
    logic                    err_timeout, rb_rst;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    reorder25_sched #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .s0_re(s0_re), .s0_im(s0_im), .s1_re(s1_re), .s1_im(s1_im),
        .s0_valid(s0_valid), .s1_valid(s1_valid),
        .s0_ready(s0_ready), .s1_ready(s1_ready),
        .gnt0(gnt0), .gnt1(gnt1),
        .rb_di_re(rb_di_re), .rb_di_im(rb_di_im), .rb_di_en(rb_di_en),
        .rb_do_en(rb_do_en), .busy(busy), .frame_done(frame_done),
        .frame_src(frame_src), .err_underrun(err_underrun)
`ifdef REORDER_SCHED_TIMEOUT_EN
        , .err_timeout(err_timeout), .rb_rst(rb_rst)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at beat 0 of LOAD; returns in the first DRAIN cycle (or at beat nbeats when cut short).
    task automatic run_load(input bit src, input int bad_a, input int bad_b, input int nbeats, input bit stray);
        bit prev_bad;
        bit bad;
        logic signed [WIDTH-1:0] e_re, e_im;
        prev_bad = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bad      = (b == bad_a) || (b == bad_b);
            s0_re    = WIDTH'(b);
            s0_im    = WIDTH'(-b);
            s1_re    = WIDTH'(200 + b);
            s1_im    = WIDTH'(300 + b);
            s0_valid = !bad;
            s1_valid = !bad;
            rb_do_en = stray;
            #1;
            e_re = bad ? '0 : (src ? WIDTH'(200 + b) : WIDTH'(b));
            e_im = bad ? '0 : (src ? WIDTH'(300 + b) : WIDTH'(-b));
            chk($sformatf("src%0d_b%0d_gnt0", src, b), gnt0, !src);
            chk($sformatf("src%0d_b%0d_gnt1", src, b), gnt1, src);
            chk($sformatf("src%0d_b%0d_s0_ready", src, b), s0_ready, !src);
            chk($sformatf("src%0d_b%0d_s1_ready", src, b), s1_ready, src);
            chk($sformatf("src%0d_b%0d_di_en", src, b), rb_di_en, 1);
            chk($sformatf("src%0d_b%0d_busy", src, b), busy, 1);
            chk($sformatf("src%0d_b%0d_di_re", src, b), rb_di_re, e_re);
            chk($sformatf("src%0d_b%0d_di_im", src, b), rb_di_im, e_im);
            chk($sformatf("src%0d_b%0d_underrun", src, b), err_underrun, prev_bad);
            chk($sformatf("src%0d_b%0d_frame_done", src, b), frame_done, 0);
            prev_bad = bad;
            step();
        end
        rb_do_en = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        if (nbeats == N) begin
            chk("drain0_gnt0", gnt0, 0);
            chk("drain0_gnt1", gnt1, 0);
            chk("drain0_di_en", rb_di_en, 0);
            chk("drain0_busy", busy, 1);
            chk("drain0_underrun", err_underrun, prev_bad);
        end
    endtask

    // Ideal buffer: N output beats starting in the first DRAIN cycle. Returns in the IDLE cycle.
    task automatic run_drain(input bit src);
        for (int k = 0; k < N; k++) begin
            rb_do_en = 1'b1;
            #1;
            chk($sformatf("drain_k%0d_frame_done", k), frame_done, 0);
            chk($sformatf("drain_k%0d_busy", k), busy, 1);
            chk($sformatf("drain_k%0d_di_en", k), rb_di_en, 0);
            step();
        end
        rb_do_en = 1'b0;
        chk("done_frame_done", frame_done, 1);
        chk("done_frame_src", frame_src, src);
        chk("done_busy", busy, 1);
        step();
        chk("gap_frame_done", frame_done, 0);
        chk("gap_busy", busy, 1);
        chk("gap_di_en", rb_di_en, 0);
        chk("gap_gnt0", gnt0, 0);
        chk("gap_gnt1", gnt1, 0);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_gnt0", gnt0, 0);
        chk("idle_gnt1", gnt1, 0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        s0_re = '0; s0_im = '0; s1_re = '0; s1_im = '0;
        s0_valid = 1'b0; s1_valid = 1'b0; rb_do_en = 1'b0;
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_di_en", rb_di_en, 0);
        chk("rst_di_re", rb_di_re, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_src", frame_src, 0);
        chk("rst_underrun", err_underrun, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_after_rst_busy", busy, 0);

        // Single frame from requester 0; req dropped mid-LOAD and stray rb_do_en during LOAD.
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        run_load(1'b0, -1, -1, N, 1'b1);
        run_drain(1'b0);

        // Underrun on beats 7 and 8.
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        run_load(1'b0, 7, 8, N, 1'b0);
        run_drain(1'b0);

        // Reset at beat 12 of a requester-1 frame.
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        run_load(1'b1, -1, -1, 12, 1'b0);
        s1_valid = 1'b1;
        s1_re = 18'sd5;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_gnt1", gnt1, 0);
        chk("midrst_s1_ready", s1_ready, 0);
        chk("midrst_di_en", rb_di_en, 0);
        chk("midrst_di_re", rb_di_re, 0);
        chk("midrst_busy", busy, 0);
        step();
        rst = 1'b0;
        s1_valid = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        run_load(1'b1, -1, -1, N, 1'b0);
        run_drain(1'b1);

        // Tie held across three frames: last-served is 1, so 0,1,0.
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        run_load(1'b0, -1, -1, N, 1'b0);
        run_drain(1'b0);
        step();
        run_load(1'b1, -1, -1, N, 1'b0);
        run_drain(1'b1);
        step();
        run_load(1'b0, -1, -1, N, 1'b0);
        run_drain(1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
